uart_cmd_sequencer: RTL and testbench

Byte-level command parser and configuration sequencer between the UART receiver and the LED matrix datapath. Consumes received bytes and decodes single-byte and multi-byte commands. Drives the channel enables and global brightness, and issues pixel writes to the framebuffer over a valid/ready handshake. Partial commands are aborted by an inter-byte timeout.

---
 rtl/uart_cmd_pkg.sv | 19 +
 rtl/uart_cmd_sequencer_if.sv | 21 ++
 rtl/cmd_timeout.sv | 22 ++
 rtl/uart_cmd_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared states, command bytes, argument counts and ack codes for uart_cmd_sequencer
package uart_cmd_pkg;
    typedef enum logic [1:0] {IDLE, ARGS, WRITE} state_t;
    localparam logic [7:0] CMD_RED_ON    = "R";
    localparam logic [7:0] CMD_RED_OFF   = "r";
    localparam logic [7:0] CMD_GREEN_ON  = "G";
    localparam logic [7:0] CMD_GREEN_OFF = "g";
    localparam logic [7:0] CMD_BLUE_ON   = "B";
    localparam logic [7:0] CMD_BLUE_OFF  = "b";
    localparam logic [7:0] CMD_LEVEL     = "L";
    localparam logic [7:0] CMD_PIXEL     = "P";
    localparam int LEVEL_ARGS = 1;
    localparam int PIXEL_ARGS = 5;
    localparam logic [7:0] ACK_OK  = 8'h4B;
    localparam logic [7:0] ACK_ERR = 8'h21;
    function automatic logic [2:0] arg_count(input logic pixel);
        return pixel ? 3'(PIXEL_ARGS) : 3'(LEVEL_ARGS);
    endfunction
endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// uart_cmd_sequencer_if: received-byte strobe plus framebuffer pixel-write handshake
interface uart_cmd_sequencer_if #(
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 6
);
    logic [7:0]                   rx_data;
    logic                         rx_valid;
    logic                         rx_invalid;
    logic                         fb_wr_valid;
    logic                         fb_wr_ready;
    logic [ROW_BITS+COL_BITS-1:0] fb_wr_addr;
    logic [23:0]                  fb_wr_data;
    modport master (
        input  rx_data, rx_valid, rx_invalid, fb_wr_ready,
        output fb_wr_valid, fb_wr_addr, fb_wr_data
    );
    modport slave (
        output rx_data, rx_valid, rx_invalid, fb_wr_ready,
        input  fb_wr_valid, fb_wr_addr, fb_wr_data
    );
endinterface

// File: rtl/cmd_timeout.sv
// cmd_timeout: saturating inter-byte counter; expire holds while parked at the terminal count
module cmd_timeout #(
    parameter int MAX_COUNT = 532000,
    parameter int WIDTH     = 20
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam logic [WIDTH-1:0] TERM = WIDTH'(MAX_COUNT - 1);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    // count up while enabled, stop at the terminal value instead of wrapping
    always_comb cnt_d = clr ? '0 : (en && cnt_q != TERM) ? cnt_q + 1'b1 : cnt_q;
    // counter register
    always_ff @(posedge clk_in) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign expire = cnt_q == TERM;
endmodule

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: UART byte command parser driving enables, brightness and pixel writes (optional CMD_ACK_EN ack channel)
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int COLS           = 64,
    parameter int ROWS           = 32,
    parameter int COL_BITS       = 6,
    parameter int ROW_BITS       = 5,
    parameter int TIMEOUT_CYCLES = 532000,
    parameter int TIMEOUT_WIDTH  = 20
) (
    input  logic                        clk_in,
    input  logic                        reset,
    uart_cmd_sequencer_if.master        bus,
    output logic                        enable_red,
    output logic                        enable_green,
    output logic                        enable_blue,
    output logic [7:0]                  brightness,
    output logic                        cmd_error,
`ifdef CMD_ACK_EN
    output logic [7:0]                  ack_data,
    output logic                        ack_valid,
    input  logic                        ack_ready,
    output logic                        ack_overflow,
`endif
    output logic                        busy
);
    state_t                       state_q, state_d;
    logic [2:0]                   idx_q, idx_d;
    logic                         pix_q, pix_d;
    logic [3:0][7:0]              arg_q, arg_d;
    logic [2:0]                   en_q, en_d;
    logic [7:0]                   bri_q, bri_d;
    logic [ROW_BITS+COL_BITS-1:0] addr_q, addr_d;
    logic [23:0]                  data_q, data_d;
    logic                         err_q, err_d;
    logic                         ok, expire, last, coord_ok;

    cmd_timeout #(.MAX_COUNT(TIMEOUT_CYCLES), .WIDTH(TIMEOUT_WIDTH)) u_timeout (
        .clk_in (clk_in),
        .reset  (reset),
        .clr    (state_q != ARGS || bus.rx_valid),
        .en     (state_q == ARGS),
        .expire (expire)
    );

    assign last     = (idx_q + 3'd1) == arg_count(pix_q);
    assign coord_ok = 32'(arg_q[0]) < COLS && 32'(arg_q[1]) < ROWS;

    // command decode, argument collection and write handshake; ok marks a completed command
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        arg_d   = arg_q;
        en_d    = en_q;
        bri_d   = bri_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = 1'b0;
        ok      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_valid && bus.rx_invalid) err_d = 1'b1;
                else if (bus.rx_valid) begin
                    case (bus.rx_data)
                        CMD_RED_ON:    begin en_d[2] = 1'b1; ok = 1'b1; end
                        CMD_RED_OFF:   begin en_d[2] = 1'b0; ok = 1'b1; end
                        CMD_GREEN_ON:  begin en_d[1] = 1'b1; ok = 1'b1; end
                        CMD_GREEN_OFF: begin en_d[1] = 1'b0; ok = 1'b1; end
                        CMD_BLUE_ON:   begin en_d[0] = 1'b1; ok = 1'b1; end
                        CMD_BLUE_OFF:  begin en_d[0] = 1'b0; ok = 1'b1; end
                        CMD_LEVEL:     begin state_d = ARGS; pix_d = 1'b0; idx_d = '0; end
                        CMD_PIXEL:     begin state_d = ARGS; pix_d = 1'b1; idx_d = '0; end
                        default:       err_d = 1'b1;
                    endcase
                end
            end
            ARGS: begin
                if (bus.rx_valid && bus.rx_invalid) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (bus.rx_valid) begin
                    idx_d = idx_q + 3'd1;
                    if (!last) arg_d[idx_q[1:0]] = bus.rx_data;
                    else begin
                        state_d = IDLE;
                        if (!pix_q) begin
                            bri_d = bus.rx_data;
                            ok    = 1'b1;
                        end else if (coord_ok) begin
                            state_d = WRITE;
                            addr_d  = {arg_q[1][ROW_BITS-1:0], arg_q[0][COL_BITS-1:0]};
                            data_d  = {arg_q[2], arg_q[3], bus.rx_data};
                        end else err_d = 1'b1;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            WRITE: begin
                err_d = bus.rx_valid;
                if (bus.fb_wr_ready) begin
                    state_d = IDLE;
                    ok      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pix_q   <= 1'b0;
            arg_q   <= '0;
            en_q    <= 3'b111;
            bri_q   <= 8'hFF;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pix_q   <= pix_d;
            arg_q   <= arg_d;
            en_q    <= en_d;
            bri_q   <= bri_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign enable_red      = en_q[2];
    assign enable_green    = en_q[1];
    assign enable_blue     = en_q[0];
    assign brightness      = bri_q;
    assign cmd_error       = err_q;
    assign busy            = state_q != IDLE;
    assign bus.fb_wr_valid = state_q == WRITE;
    assign bus.fb_wr_addr  = addr_q;
    assign bus.fb_wr_data  = data_q;

`ifdef CMD_ACK_EN
    logic       ack_valid_q, ack_valid_d, ack_ovf_q, ack_ovf_d, ack_free;
    logic [7:0] ack_data_q, ack_data_d;
    // one-entry ack holder; an ack that finds it occupied (or a second ack in the same cycle) is dropped and flagged
    always_comb begin
        ack_free    = !ack_valid_q || ack_ready;
        ack_valid_d = ack_valid_q && !ack_ready;
        ack_data_d  = ack_data_q;
        ack_ovf_d   = ack_ovf_q;
        if ((err_d || ok) && ack_free) begin
            ack_valid_d = 1'b1;
            ack_data_d  = err_d ? ACK_ERR : ACK_OK;
        end
        if ((err_d || ok) && (!ack_free || (err_d && ok))) ack_ovf_d = 1'b1;
    end
    // ack registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            ack_valid_q <= 1'b0;
            ack_data_q  <= '0;
            ack_ovf_q   <= 1'b0;
        end else begin
            ack_valid_q <= ack_valid_d;
            ack_data_q  <= ack_data_d;
            ack_ovf_q   <= ack_ovf_d;
        end
    end
    assign ack_valid    = ack_valid_q;
    assign ack_data     = ack_data_q;
    assign ack_overflow = ack_ovf_q;
`else
    logic unused_ok;
    assign unused_ok = ok;
`endif
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer: vector table, corner-case sequences and randomized traffic against a byte-stream model
module tb_uart_cmd_sequencer;
    localparam int T = 40;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       enable_red, enable_green, enable_blue, cmd_error, busy;
    logic [7:0] brightness;
`ifdef CMD_ACK_EN
    logic [7:0] ack_data;
    logic       ack_valid, ack_ready, ack_overflow;
`endif

    uart_cmd_sequencer_if #(.ROW_BITS(5), .COL_BITS(6)) bus ();

    uart_cmd_sequencer #(.TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(6)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .bus          (bus),
        .enable_red   (enable_red),
        .enable_green (enable_green),
        .enable_blue  (enable_blue),
        .brightness   (brightness),
        .cmd_error    (cmd_error),
`ifdef CMD_ACK_EN
        .ack_data     (ack_data),
        .ack_valid    (ack_valid),
        .ack_ready    (ack_ready),
        .ack_overflow (ack_overflow),
`endif
        .busy         (busy)
    );

    always #5 clk_in = ~clk_in;

    int          tests = 0, fails = 0, err_seen = 0;
    logic        ready_req = 1'b0, ready_rand = 1'b0;
    logic [34:0] got_q[$];

    always @(posedge clk_in) begin
        #2 bus.fb_wr_ready = ready_rand ? 1'($urandom) : ready_req;
    end

    always @(negedge clk_in) begin
        if (cmd_error) err_seen++;
        if (bus.fb_wr_valid && bus.fb_wr_ready) got_q.push_back({bus.fb_wr_addr, bus.fb_wr_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic inv);
        bus.rx_data    = b;
        bus.rx_valid   = 1'b1;
        bus.rx_invalid = inv;
        @(negedge clk_in);
        bus.rx_valid   = 1'b0;
        bus.rx_invalid = 1'b0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.rx_valid   = 1'b0;
        bus.rx_invalid = 1'b0;
        bus.rx_data    = '0;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
    endtask

    task automatic wait_write_done();
        int c = 0;
        while (bus.fb_wr_valid && c < 200) begin
            @(negedge clk_in);
            c++;
        end
        check("write_done", bus.fb_wr_valid, 0);
    endtask

    // behavioural model: processes the byte stream as whole commands
    logic [2:0]  m_en;
    logic [7:0]  m_bri, m_cmd;
    int          m_err;
    logic [7:0]  m_args[$];
    logic [34:0] m_wr[$];

    function automatic void model_reset();
        m_en = 3'b111; m_bri = 8'hFF; m_cmd = 8'h00; m_err = 0;
        m_args.delete(); m_wr.delete();
    endfunction

    function automatic void model(input logic [7:0] b, input logic inv);
        logic [7:0] c, r;
        if (inv) begin
            m_err++; m_cmd = 8'h00; m_args.delete();
            return;
        end
        if (m_cmd == 8'h00) begin
            case (b)
                "R": m_en[2] = 1'b1;
                "r": m_en[2] = 1'b0;
                "G": m_en[1] = 1'b1;
                "g": m_en[1] = 1'b0;
                "B": m_en[0] = 1'b1;
                "b": m_en[0] = 1'b0;
                "L", "P": m_cmd = b;
                default: m_err++;
            endcase
            return;
        end
        m_args.push_back(b);
        if (m_cmd == "L") begin
            m_bri = b; m_cmd = 8'h00; m_args.delete();
        end else if (m_args.size() == 5) begin
            c = m_args[0];
            r = m_args[1];
            if (c < 64 && r < 32) m_wr.push_back({r[4:0], c[5:0], m_args[2], m_args[3], m_args[4]});
            else m_err++;
            m_cmd = 8'h00; m_args.delete();
        end
    endfunction

    typedef struct packed {
        logic [7:0] b;
        logic       inv;
        logic [2:0] en;
        logic [7:0] bri;
        logic       err;
        logic       busy;
    } vec_t;
    vec_t vecs[16];
    logic [7:0] letters[6];

    initial begin
        int n0, base_err;
        logic [7:0] q[$];
        vecs = '{
            '{8'h72, 1'b0, 3'b011, 8'hFF, 1'b0, 1'b0},
            '{8'h67, 1'b0, 3'b001, 8'hFF, 1'b0, 1'b0},
            '{8'h42, 1'b0, 3'b001, 8'hFF, 1'b0, 1'b0},
            '{8'h62, 1'b0, 3'b000, 8'hFF, 1'b0, 1'b0},
            '{8'h52, 1'b0, 3'b100, 8'hFF, 1'b0, 1'b0},
            '{8'h78, 1'b0, 3'b100, 8'hFF, 1'b1, 1'b0},
            '{8'h72, 1'b1, 3'b100, 8'hFF, 1'b1, 1'b0},
            '{8'h4C, 1'b0, 3'b100, 8'hFF, 1'b0, 1'b1},
            '{8'h40, 1'b0, 3'b100, 8'h40, 1'b0, 1'b0},
            '{8'h4C, 1'b0, 3'b100, 8'h40, 1'b0, 1'b1},
            '{8'h47, 1'b0, 3'b100, 8'h47, 1'b0, 1'b0},
            '{8'h47, 1'b0, 3'b110, 8'h47, 1'b0, 1'b0},
            '{8'h10, 1'b0, 3'b110, 8'h47, 1'b1, 1'b0},
            '{8'h4C, 1'b0, 3'b110, 8'h47, 1'b0, 1'b1},
            '{8'h72, 1'b1, 3'b110, 8'h47, 1'b1, 1'b0},
            '{8'h99, 1'b0, 3'b110, 8'h47, 1'b1, 1'b0}
        };
        letters = '{"R", "r", "G", "g", "B", "b"};
`ifdef CMD_ACK_EN
        ack_ready = 1'b1;
`endif
        do_reset();

        check("rst_en", {enable_red, enable_green, enable_blue}, 3'b111);
        check("rst_bri", brightness, 8'hFF);
        check("rst_valid", bus.fb_wr_valid, 0);
        check("rst_addr", bus.fb_wr_addr, 0);
        check("rst_data", bus.fb_wr_data, 0);
        check("rst_err", cmd_error, 0);
        check("rst_busy", busy, 0);

        for (int i = 0; i < 16; i++) begin
            send(vecs[i].b, vecs[i].inv);
            check($sformatf("vec%0d_en", i), {enable_red, enable_green, enable_blue}, vecs[i].en);
            check($sformatf("vec%0d_bri", i), brightness, vecs[i].bri);
            check($sformatf("vec%0d_err", i), cmd_error, vecs[i].err);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
        end

        // pixel write held off by ready for 4 cycles
        do_reset();
        n0 = got_q.size();
        q = '{"P", 8'h05, 8'h03, 8'h11, 8'h22, 8'h33};
        foreach (q[i]) send(q[i], 1'b0);
        check("px_valid", bus.fb_wr_valid, 1);
        check("px_addr", bus.fb_wr_addr, 11'h0C5);
        check("px_data", bus.fb_wr_data, 24'h112233);
        check("px_err", cmd_error, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            check("px_hold_valid", bus.fb_wr_valid, 1);
            check("px_hold_addr", bus.fb_wr_addr, 11'h0C5);
            check("px_hold_data", bus.fb_wr_data, 24'h112233);
        end
        check("px_no_xfer", got_q.size(), n0);
        ready_req = 1'b1;
        repeat (2) @(negedge clk_in);
        check("px_done_valid", bus.fb_wr_valid, 0);
        @(negedge clk_in);
        check("px_one_xfer", got_q.size(), n0 + 1);
        check("px_xfer_word", got_q[got_q.size()-1], {11'h0C5, 24'h112233});

        // ready already high when the write starts
        n0 = got_q.size();
        q = '{"P", 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        foreach (q[i]) send(q[i], 1'b0);
        check("px1_valid", bus.fb_wr_valid, 1);
        @(negedge clk_in);
        check("px1_done", bus.fb_wr_valid, 0);
        check("px1_xfer", got_q.size(), n0 + 1);
        check("px1_word", got_q[got_q.size()-1], {11'h081, 24'h030405});

        // overrun byte during a stalled write at the max coordinates
        ready_req = 1'b0;
        repeat (2) @(negedge clk_in);
        n0 = got_q.size();
        q = '{"P", 8'd63, 8'd31, 8'hAA, 8'hBB, 8'hCC};
        foreach (q[i]) send(q[i], 1'b0);
        check("ovr_addr", bus.fb_wr_addr, 11'h7FF);
        send("r", 1'b0);
        check("ovr_err", cmd_error, 1);
        check("ovr_valid", bus.fb_wr_valid, 1);
        check("ovr_red", enable_red, 1);
        ready_req = 1'b1;
        repeat (3) @(negedge clk_in);
        check("ovr_err_once", cmd_error, 0);
        check("ovr_xfer", got_q.size(), n0 + 1);
        check("ovr_word", got_q[got_q.size()-1], {11'h7FF, 24'hAABBCC});

        // out-of-range coordinates
        n0 = got_q.size();
        q = '{"P", 8'd64, 8'h00, 8'h01, 8'h02, 8'h03};
        foreach (q[i]) send(q[i], 1'b0);
        check("col_err", cmd_error, 1);
        check("col_valid", bus.fb_wr_valid, 0);
        check("col_busy", busy, 0);
        @(negedge clk_in);
        check("col_err_once", cmd_error, 0);
        q = '{"P", 8'h00, 8'd32, 8'h01, 8'h02, 8'h03};
        foreach (q[i]) send(q[i], 1'b0);
        check("row_err", cmd_error, 1);
        @(negedge clk_in);
        check("oor_no_xfer", got_q.size(), n0);

        // inter-byte timeout, then a stray byte decoded as a command
        do_reset();
        send("L", 1'b0);
        repeat (T - 1) @(negedge clk_in);
        check("to_pre_busy", busy, 1);
        check("to_pre_err", cmd_error, 0);
        @(negedge clk_in);
        check("to_err", cmd_error, 1);
        check("to_busy", busy, 0);
        @(negedge clk_in);
        check("to_err_once", cmd_error, 0);
        send(8'h10, 1'b0);
        check("to_stray_err", cmd_error, 1);
        check("to_bri", brightness, 8'hFF);

        // byte arriving on the expiry cycle is accepted
        send("L", 1'b0);
        repeat (T - 1) @(negedge clk_in);
        send(8'h22, 1'b0);
        check("exp_bri", brightness, 8'h22);
        check("exp_err", cmd_error, 0);
        check("exp_busy", busy, 0);

        // reset discards a partial command without an error
        send("L", 1'b0);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        check("rstp_err", cmd_error, 0);
        check("rstp_busy", busy, 0);
        send(8'h33, 1'b0);
        check("rstp_stray", cmd_error, 1);
        check("rstp_bri", brightness, 8'hFF);

`ifdef CMD_ACK_EN
        do_reset();
        ack_ready = 1'b0;
        send("L", 1'b0);
        send(8'h00, 1'b1);
        check("ack_err_valid", ack_valid, 1);
        check("ack_err_data", ack_data, 8'h21);
        check("ack_no_ovf", ack_overflow, 0);
        send(8'h7E, 1'b0);
        check("ack_ovf", ack_overflow, 1);
        ack_ready = 1'b1;
`endif

        // randomized command traffic against the model
        do_reset();
        model_reset();
        @(negedge clk_in);
        got_q.delete();
        base_err   = err_seen;
        ready_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            int k;
            k = $urandom_range(0, 9);
            q.delete();
            if (k < 3) q.push_back(letters[$urandom_range(0, 5)]);
            else if (k < 5) begin
                q.push_back("L");
                q.push_back(8'($urandom));
            end else if (k < 8) begin
                q.push_back("P");
                q.push_back(8'($urandom_range(0, 70)));
                q.push_back(8'($urandom_range(0, 36)));
                repeat (3) q.push_back(8'($urandom));
            end else q.push_back(8'($urandom));
            foreach (q[i]) begin
                logic inv;
                wait_write_done();
                repeat ($urandom_range(0, 4)) @(negedge clk_in);
                inv = $urandom_range(0, 24) == 0;
                model(q[i], inv);
                send(q[i], inv);
                check("rnd_en", {enable_red, enable_green, enable_blue}, m_en);
                check("rnd_bri", brightness, m_bri);
            end
        end
        wait_write_done();
        @(negedge clk_in);
        check("rnd_err_count", err_seen - base_err, m_err);
        check("rnd_wr_count", got_q.size(), m_wr.size());
        for (int i = 0; i < got_q.size() && i < m_wr.size(); i++) check("rnd_wr", got_q[i], m_wr[i]);
        ready_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
